seu_npu_layer_para_loader: RTL and testbench
============================================

// Module: seu_npu_layer_para_loader
// PURPOSE
//  Upstream feeder of the NPU master control unit. On start, walks the layer-parameter table in DDR,
//  starting at nn_layer_para_saddr: one descriptor of PARA_WORDS words per layer, nn_layers_num layers.
//  Hands each descriptor to the MCU over a valid/ready port, with per-layer input/output map addresses
//  resolved by ping-pong between map0 and map1.
// PARAMETERS
//  AW          32  DDR byte-address width
//  DW          64  DDR read-data width (bits)
//  PARA_WORDS  4   DW-wide words per layer descriptor; STRIDE = PARA_WORDS*DW/8 bytes (32 by default)
// PORTS
//  clk_trans           in   1             single clock, all logic on rising edge
//  rst_n               in   1             asynchronous reset, active low
//  start               in   1             1-cycle pulse: begin table walk (ignored unless IDLE)
//  abort               in   1             level/pulse: stop walk, return to IDLE
//  nn_layer_para_saddr in   AW            table base address
//  nn_first_map_saddr  in   AW            layer-0 input map address
//  nn_map0_saddr       in   AW            ping map buffer address
//  nn_map1_saddr       in   AW            pong map buffer address
//  nn_layers_num       in   8             number of layers (0..255)
//  rd_req_valid        out  1             DDR read request valid
//  rd_req_ready        in   1             DDR read request accepted
//  rd_req_addr         out  AW            burst start address
//  rd_req_len          out  8             burst length in beats = PARA_WORDS (constant)
//  rd_rsp_valid        in   1             response beat valid (loader always accepts)
//  rd_rsp_data         in   DW            response beat
//  rd_rsp_last         in   1             final beat of burst
//  lp_valid            out  1             descriptor available to MCU
//  lp_ready            in   1             MCU consumes descriptor
//  lp_desc             out  PARA_WORDS*DW word k at bits [k*DW +: DW], word 0 = first beat
//  lp_layer_idx        out  8             index of current layer
//  lp_in_map_saddr     out  AW            input feature-map address for this layer
//  lp_out_map_saddr    out  AW            output feature-map address for this layer
//  lp_last_layer       out  1             idx == layers_num-1
//  busy                out  1             state != IDLE
//  done                out  1             1-cycle pulse at completion (also for layers_num==0)
//  proto_err           out  1             sticky: rd_rsp_last beat count != PARA_WORDS; cleared by start
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, idx 0, desc regs 0; proto_err 0.
//  - FSM IDLE -> REQ -> RECV -> HOLD -> (REQ | IDLE); DRAIN for abort during RECV.
//  - IDLE: start latches all nn_* inputs.
//    - layers_num==0: done=1 next cycle, stay IDLE.
//    - otherwise: idx=0, go to REQ.
//  - REQ: rd_req_valid=1, rd_req_addr = base + idx*STRIDE (mod 2^AW, wraps silently).
//    Addr stable while valid && !ready. Move to RECV on handshake; beat counter cnt=0.
//  - RECV: each rd_rsp_valid beat is written to word cnt, then cnt++.
//    - Normal end: beat with cnt==PARA_WORDS-1 -> HOLD.
//    - Early rd_rsp_last: set proto_err, zero unfilled words, go to HOLD.
//    - Late (no last on beat PARA_WORDS-1): set proto_err, go to HOLD; extra beats ignored until last.
//  - HOLD: lp_valid=1; lp_* stable until lp_ready.
//    - On lp_valid&&lp_ready, if lp_last_layer: done pulse next cycle, IDLE.
//    - Otherwise: idx++, REQ (next rd_req_valid the cycle after handshake).
//  - Map ping-pong: idx==0 in=first_map, out=map0. idx>0: in=(idx-1) even ? map0 : map1; out=idx even ? map0 : map1.
//  - Latency: start -> rd_req_valid 1 cycle; accepting last beat -> lp_valid 1 cycle.
//  - abort:
//    - Priority over all other events in the same cycle.
//    - In REQ, HOLD or IDLE: IDLE next cycle, rd_req_valid/lp_valid drop, no done.
//    - In RECV: DRAIN, swallow beats until rd_rsp_last, then IDLE. Never abandon an accepted burst.
//    - start in the same cycle as abort is ignored.
//  - start while busy: ignored. Inputs nn_* may change after start without effect.
//  - rst_n low mid-operation: immediate return to reset values. Outstanding DDR beats are the system's responsibility.
// TESTING
//  T1 base=0x1000_0000, layers=3, ready=1, beats in order -> req addrs 0x1000_0000/0x20/0x40;
//     in/out = first/map0, map0/map1, map1/map0; lp_last_layer on idx 2; done 1 cycle after 3rd lp handshake.
//  T2 layers=0, start -> no rd_req_valid, done=1 exactly one cycle later, busy stays 0.
//  T3 rd_req_ready low 5 cycles, lp_ready low 7 cycles -> addr/desc held stable, no duplicate requests.
//  T4 rd_rsp_last on beat 2 (PARA_WORDS=4) -> proto_err=1, lp_desc word3=0, walk continues; next start clears proto_err.
//  T5 abort after 2 beats of burst -> DRAIN consumes beats 3,4; IDLE after last; lp_valid never asserts; no done.
//  T6 base=0xFFFF_FFE0, layers=2 -> 2nd req addr 0x0000_0000; rst_n pulse during HOLD -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/seu_npu_layer_para_loader_if.sv
// ----------------------------------------------------------------------------
// seu_npu_layer_para_loader_if
//  Bus bundle of the layer-parameter loader:
//   - DDR read request channel   (rd_req_*)  loader -> memory
//   - DDR read response channel  (rd_rsp_*)  memory -> loader
//   - descriptor port to the MCU (lp_*)      loader -> MCU
//  modport master : loader side
//  modport slave  : environment side (DDR model + MCU)
// ----------------------------------------------------------------------------
interface seu_npu_layer_para_loader_if #(
    parameter int AW         = 32,
    parameter int DW         = 64,
    parameter int PARA_WORDS = 4
);
    logic                       rd_req_valid;
    logic                       rd_req_ready;
    logic [AW-1:0]              rd_req_addr;
    logic [7:0]                 rd_req_len;
    logic                       rd_rsp_valid;
    logic [DW-1:0]              rd_rsp_data;
    logic                       rd_rsp_last;
    logic                       lp_valid;
    logic                       lp_ready;
    logic [PARA_WORDS*DW-1:0]   lp_desc;
    logic [7:0]                 lp_layer_idx;
    logic [AW-1:0]              lp_in_map_saddr;
    logic [AW-1:0]              lp_out_map_saddr;
    logic                       lp_last_layer;

    modport master (
        output rd_req_valid, rd_req_addr, rd_req_len,
        input  rd_req_ready,
        input  rd_rsp_valid, rd_rsp_data, rd_rsp_last,
        output lp_valid, lp_desc, lp_layer_idx, lp_in_map_saddr, lp_out_map_saddr, lp_last_layer,
        input  lp_ready
    );

    modport slave (
        input  rd_req_valid, rd_req_addr, rd_req_len,
        output rd_req_ready,
        output rd_rsp_valid, rd_rsp_data, rd_rsp_last,
        input  lp_valid, lp_desc, lp_layer_idx, lp_in_map_saddr, lp_out_map_saddr, lp_last_layer,
        output lp_ready
    );
endinterface

// File: rtl/seu_npu_layer_para_loader.sv
// ----------------------------------------------------------------------------
// seu_npu_layer_para_loader
//  Walks the layer-parameter table in DDR (one PARA_WORDS-word descriptor per
//  layer) and hands each descriptor to the NPU MCU with ping-pong resolved
//  input/output feature-map addresses.
//  Ports:
//   clk_trans, rst_n          clock, async active-low reset
//   start, abort              walk control
//   nn_*                      walk configuration, latched on accepted start
//   bus (master)              DDR read req/rsp channels and MCU descriptor port
//   busy, done, proto_err     status (proto_err sticky, cleared by start)
// ----------------------------------------------------------------------------
module seu_npu_layer_para_loader #(
    parameter int AW         = 32,
    parameter int DW         = 64,
    parameter int PARA_WORDS = 4
) (
    input  logic                        clk_trans,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic [AW-1:0]               nn_layer_para_saddr,
    input  logic [AW-1:0]               nn_first_map_saddr,
    input  logic [AW-1:0]               nn_map0_saddr,
    input  logic [AW-1:0]               nn_map1_saddr,
    input  logic [7:0]                  nn_layers_num,
    seu_npu_layer_para_loader_if.master bus,
    output logic                        busy,
    output logic                        done,
    output logic                        proto_err
);
    localparam int STRIDE = PARA_WORDS * DW / 8;
    localparam int IW     = (PARA_WORDS > 1) ? $clog2(PARA_WORDS) : 1;

    typedef enum logic [2:0] {IDLE, REQ, RECV, DRAIN, HOLD} state_t;

    state_t                         r_state;
    logic [7:0]                     r_idx;
    logic [7:0]                     r_num;
    logic [IW-1:0]                  r_cnt;
    logic [AW-1:0]                  r_map0;
    logic [AW-1:0]                  r_map1;
    logic [AW-1:0]                  r_req_addr;
    logic [AW-1:0]                  r_in;
    logic [AW-1:0]                  r_out;
    logic                           r_last;
    logic                           r_req_valid;
    logic                           r_lp_valid;
    logic                           r_done;
    logic                           r_perr;
    logic                           r_skip;   // tail of an over-long burst still to be swallowed
    logic [PARA_WORDS-1:0][DW-1:0]  r_desc;

    logic w_beat;
    logic w_end;
    logic w_final;

    // Beats belonging to an over-long previous burst are never real data.
    assign w_beat  = bus.rd_rsp_valid && !r_skip;
    assign w_final = (r_cnt == IW'(PARA_WORDS - 1));
    assign w_end   = w_beat && (bus.rd_rsp_last || w_final);

    always_ff @(posedge clk_trans or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_num       <= '0;
            r_cnt       <= '0;
            r_map0      <= '0;
            r_map1      <= '0;
            r_req_addr  <= '0;
            r_in        <= '0;
            r_out       <= '0;
            r_last      <= 1'b0;
            r_req_valid <= 1'b0;
            r_lp_valid  <= 1'b0;
            r_done      <= 1'b0;
            r_perr      <= 1'b0;
            r_skip      <= 1'b0;
            r_desc      <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_skip && bus.rd_rsp_valid && bus.rd_rsp_last)
                r_skip <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (start && !abort) begin
                        r_perr <= 1'b0;
                        r_num  <= nn_layers_num;
                        r_map0 <= nn_map0_saddr;
                        r_map1 <= nn_map1_saddr;
                        if (nn_layers_num == 8'd0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_idx       <= '0;
                            r_req_addr  <= nn_layer_para_saddr;
                            r_in        <= nn_first_map_saddr;
                            r_out       <= nn_map0_saddr;
                            r_last      <= (nn_layers_num == 8'd1);
                            r_req_valid <= 1'b1;
                            r_state     <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (abort) begin
                        r_req_valid <= 1'b0;
                        r_state     <= IDLE;
                    end else if (bus.rd_req_ready) begin
                        r_req_valid <= 1'b0;
                        r_cnt       <= '0;
                        r_desc      <= '0;   // words not delivered by a short burst read as 0
                        r_state     <= RECV;
                    end
                end
                RECV: begin
                    if (w_beat) begin
                        r_desc[r_cnt] <= bus.rd_rsp_data;
                        r_cnt         <= r_cnt + 1'b1;
                    end
                    if (w_end) begin
                        if (bus.rd_rsp_last != w_final)
                            r_perr <= 1'b1;
                        if (!bus.rd_rsp_last)
                            r_skip <= 1'b1;
                        if (abort) begin
                            r_state <= IDLE;
                        end else begin
                            r_lp_valid <= 1'b1;
                            r_state    <= HOLD;
                        end
                    end else if (abort) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_beat && bus.rd_rsp_last)
                        r_state <= IDLE;
                end
                HOLD: begin
                    if (abort) begin
                        r_lp_valid <= 1'b0;
                        r_state    <= IDLE;
                    end else if (bus.lp_ready) begin
                        r_lp_valid <= 1'b0;
                        if (r_last) begin
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            // Next layer reads what this one wrote; its output
                            // goes to map0 on even indices, map1 on odd.
                            r_idx       <= r_idx + 8'd1;
                            r_req_addr  <= r_req_addr + AW'(STRIDE);
                            r_in        <= r_out;
                            r_out       <= r_idx[0] ? r_map0 : r_map1;
                            r_last      <= ((r_idx + 8'd1) == (r_num - 8'd1));
                            r_req_valid <= 1'b1;
                            r_state     <= REQ;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.rd_req_valid     = r_req_valid;
    assign bus.rd_req_addr      = r_req_addr;
    assign bus.rd_req_len       = 8'(PARA_WORDS);
    assign bus.lp_valid         = r_lp_valid;
    assign bus.lp_desc          = r_desc;
    assign bus.lp_layer_idx     = r_idx;
    assign bus.lp_in_map_saddr  = r_in;
    assign bus.lp_out_map_saddr = r_out;
    assign bus.lp_last_layer    = r_last;
    assign busy                 = (r_state != IDLE);
    assign done                 = r_done;
    assign proto_err            = r_perr;
endmodule

// File: tb/tb_seu_npu_layer_para_loader.sv
module tb_seu_npu_layer_para_loader;
    localparam logic [31:0] FIRST = 32'h0000_A000;
    localparam logic [31:0] MAP0  = 32'h0000_B000;
    localparam logic [31:0] MAP1  = 32'h0000_C000;

    logic        clk_trans = 1'b0;
    logic        rst_n     = 1'b0;
    logic        start     = 1'b0;
    logic        abort     = 1'b0;
    logic [31:0] nn_layer_para_saddr = '0;
    logic [31:0] nn_first_map_saddr  = FIRST;
    logic [31:0] nn_map0_saddr       = MAP0;
    logic [31:0] nn_map1_saddr       = MAP1;
    logic [7:0]  nn_layers_num       = '0;
    logic        busy, done, proto_err;

    int nchk  = 0;
    int nfail = 0;

    seu_npu_layer_para_loader_if #(.AW(32), .DW(64), .PARA_WORDS(4)) bus ();

    seu_npu_layer_para_loader #(.AW(32), .DW(64), .PARA_WORDS(4)) dut (
        .clk_trans           (clk_trans),
        .rst_n               (rst_n),
        .start               (start),
        .abort               (abort),
        .nn_layer_para_saddr (nn_layer_para_saddr),
        .nn_first_map_saddr  (nn_first_map_saddr),
        .nn_map0_saddr       (nn_map0_saddr),
        .nn_map1_saddr       (nn_map1_saddr),
        .nn_layers_num       (nn_layers_num),
        .bus                 (bus),
        .busy                (busy),
        .done                (done),
        .proto_err           (proto_err)
    );

    always #5 clk_trans = ~clk_trans;

    task automatic step();
        @(posedge clk_trans);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] beatval(input int idx, input int k);
        return 64'hDEAD_0000_0000_0000 | (64'(idx) << 8) | 64'(k);
    endfunction

    // Descriptor with the first n words delivered, the rest zero.
    function automatic logic [255:0] mkdesc(input int idx, input int n);
        logic [255:0] d;
        d = '0;
        for (int k = 0; k < n; k++) d[k*64 +: 64] = beatval(idx, k);
        return d;
    endfunction

    task automatic send_burst(input int nbeats, input int last_at, input int idx, input int first_k);
        for (int k = 0; k < nbeats; k++) begin
            bus.rd_rsp_valid = 1'b1;
            bus.rd_rsp_data  = beatval(idx, first_k + k);
            bus.rd_rsp_last  = (k == last_at);
            step();
        end
        bus.rd_rsp_valid = 1'b0;
        bus.rd_rsp_last  = 1'b0;
    endtask

    // One full layer: request seen now, accept it, 4 beats, check HOLD, handshake.
    task automatic run_layer(input int idx, input logic [31:0] addr, input logic [31:0] in_m,
                             input logic [31:0] out_m, input logic last);
        chk($sformatf("req_valid_L%0d", idx), bus.rd_req_valid, 1'b1);
        chk($sformatf("req_addr_L%0d", idx), bus.rd_req_addr, addr);
        bus.rd_req_ready = 1'b1;
        step();
        chk($sformatf("req_drop_L%0d", idx), bus.rd_req_valid, 1'b0);
        send_burst(4, 3, idx, 0);
        chk($sformatf("lp_valid_L%0d", idx), bus.lp_valid, 1'b1);
        chk($sformatf("lp_idx_L%0d", idx), bus.lp_layer_idx, 8'(idx));
        chk($sformatf("lp_in_L%0d", idx), bus.lp_in_map_saddr, in_m);
        chk($sformatf("lp_out_L%0d", idx), bus.lp_out_map_saddr, out_m);
        chk($sformatf("lp_last_L%0d", idx), bus.lp_last_layer, last);
        chk($sformatf("lp_desc_L%0d", idx), bus.lp_desc, mkdesc(idx, 4));
        bus.lp_ready = 1'b1;
        step();
        bus.lp_ready = 1'b0;
        chk($sformatf("lp_drop_L%0d", idx), bus.lp_valid, 1'b0);
    endtask

    task automatic do_start(input logic [31:0] base, input logic [7:0] num);
        nn_layer_para_saddr = base;
        nn_layers_num       = num;
        start = 1'b1;
        step();
        start = 1'b0;
        // config may change freely after start
        nn_layer_para_saddr = 32'h5555_5555;
        nn_map0_saddr       = 32'h6666_6666;
    endtask

    initial begin
        logic [255:0] d_hold;
        bus.rd_req_ready = 1'b1;
        bus.rd_rsp_valid = 1'b0;
        bus.rd_rsp_data  = '0;
        bus.rd_rsp_last  = 1'b0;
        bus.lp_ready     = 1'b0;

        // Reset state
        step(); step();
        rst_n = 1'b1;
        step();
        chk("rst_req_valid", bus.rd_req_valid, 1'b0);
        chk("rst_lp_valid", bus.lp_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_perr", proto_err, 1'b0);
        chk("rst_desc", bus.lp_desc, 256'd0);
        chk("rst_idx", bus.lp_layer_idx, 8'd0);

        // T1: three layers, straight-through
        nn_map0_saddr = MAP0;
        do_start(32'h1000_0000, 8'd3);
        nn_map0_saddr = MAP0;
        chk("t1_busy", busy, 1'b1);
        chk("t1_len", bus.rd_req_len, 8'd4);
        run_layer(0, 32'h1000_0000, FIRST, MAP0, 1'b0);
        run_layer(1, 32'h1000_0020, MAP0, MAP1, 1'b0);
        run_layer(2, 32'h1000_0040, MAP1, MAP0, 1'b1);
        chk("t1_done", done, 1'b1);
        chk("t1_idle", busy, 1'b0);
        step();
        chk("t1_done_pulse", done, 1'b0);

        // T2: zero layers
        do_start(32'h1000_0000, 8'd0);
        nn_map0_saddr = MAP0;
        chk("t2_done", done, 1'b1);
        chk("t2_busy", busy, 1'b0);
        chk("t2_noreq", bus.rd_req_valid, 1'b0);
        step();
        chk("t2_done_pulse", done, 1'b0);
        chk("t2_noreq2", bus.rd_req_valid, 1'b0);

        // T3: back-pressure on both ports
        bus.rd_req_ready = 1'b0;
        do_start(32'h0000_4000, 8'd1);
        nn_map0_saddr = MAP0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t3_req_hold%0d", i), bus.rd_req_valid, 1'b1);
            chk($sformatf("t3_addr_hold%0d", i), bus.rd_req_addr, 32'h0000_4000);
            step();
        end
        bus.rd_req_ready = 1'b1;
        step();
        chk("t3_req_once", bus.rd_req_valid, 1'b0);
        send_burst(4, 3, 0, 0);
        d_hold = mkdesc(0, 4);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("t3_lp_hold%0d", i), bus.lp_valid, 1'b1);
            chk($sformatf("t3_desc_hold%0d", i), bus.lp_desc, d_hold);
            chk($sformatf("t3_nodup%0d", i), bus.rd_req_valid, 1'b0);
            step();
        end
        bus.lp_ready = 1'b1;
        step();
        bus.lp_ready = 1'b0;
        chk("t3_done", done, 1'b1);

        // T4: short burst (last on third beat)
        do_start(32'h0000_2000, 8'd2);
        nn_map0_saddr = MAP0;
        chk("t4_req", bus.rd_req_valid, 1'b1);
        step();
        send_burst(3, 2, 0, 0);
        chk("t4_lp_valid", bus.lp_valid, 1'b1);
        chk("t4_perr", proto_err, 1'b1);
        chk("t4_desc_w3zero", bus.lp_desc, mkdesc(0, 3));
        bus.lp_ready = 1'b1;
        step();
        bus.lp_ready = 1'b0;
        run_layer(1, 32'h0000_2020, MAP0, MAP1, 1'b1);
        chk("t4_done", done, 1'b1);
        chk("t4_perr_sticky", proto_err, 1'b1);
        step();

        // T5: abort mid-burst, drain rest
        do_start(32'h0000_3000, 8'd2);
        nn_map0_saddr = MAP0;
        chk("t5_perr_clr", proto_err, 1'b0);
        step();
        send_burst(2, -1, 0, 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t5_drain_busy", busy, 1'b1);
        chk("t5_drain_lp", bus.lp_valid, 1'b0);
        send_burst(1, -1, 0, 2);
        chk("t5_drain_busy2", busy, 1'b1);
        send_burst(1, 0, 0, 3);
        chk("t5_idle", busy, 1'b0);
        chk("t5_no_lp", bus.lp_valid, 1'b0);
        chk("t5_no_done", done, 1'b0);
        chk("t5_no_req", bus.rd_req_valid, 1'b0);
        step();
        chk("t5_no_done2", done, 1'b0);

        // T6: address wrap, then async reset in HOLD
        do_start(32'hFFFF_FFE0, 8'd2);
        nn_map0_saddr = MAP0;
        run_layer(0, 32'hFFFF_FFE0, FIRST, MAP0, 1'b0);
        chk("t6_wrap_addr", bus.rd_req_addr, 32'h0000_0000);
        step();
        send_burst(4, 3, 1, 0);
        chk("t6_hold", bus.lp_valid, 1'b1);
        chk("t6_hold_in", bus.lp_in_map_saddr, MAP0);
        chk("t6_hold_out", bus.lp_out_map_saddr, MAP1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_lp_valid", bus.lp_valid, 1'b0);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_desc", bus.lp_desc, 256'd0);
        chk("t6_rst_idx", bus.lp_layer_idx, 8'd0);
        chk("t6_rst_in", bus.lp_in_map_saddr, 32'd0);
        chk("t6_rst_out", bus.lp_out_map_saddr, 32'd0);
        chk("t6_rst_last", bus.lp_last_layer, 1'b0);
        chk("t6_rst_addr", bus.rd_req_addr, 32'd0);
        chk("t6_rst_req", bus.rd_req_valid, 1'b0);
        chk("t6_rst_done", done, 1'b0);
        step();
        rst_n = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
